// File: rtl/bus_periph_pkg.sv
// Shared register map, bit positions and state encoding for the CPU-bus interval timer.
package bus_periph_pkg;

  localparam logic [1:0] OFS_CNT_LO = 2'd0;
  localparam logic [1:0] OFS_CNT_HI = 2'd1;
  localparam logic [1:0] OFS_CTRL   = 2'd2;
  localparam logic [1:0] OFS_STATUS = 2'd3;

  localparam int CTRL_EN    = 0;
  localparam int CTRL_CONT  = 1;
  localparam int CTRL_IE    = 2;
  localparam int STATUS_EXP = 0;

  localparam logic [15:0] LATCH_RESET = 16'hFFFF;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } timer_state_t;

endpackage

// File: rtl/timer_prescaler.sv
// Divides PHI_2 by PRESCALE while enabled; tick marks the last cycle of each period.
module timer_prescaler #(
  parameter int PRESCALE = 8,
  parameter int PS_W     = 8
) (
  input  logic PHI_2,
  input  logic RES,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam logic [PS_W-1:0] LAST = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0] count;

  // tick is not gated by clr so an expiry on a restart edge is still seen by the top
  assign tick = en && (count == LAST);

  always_ff @(posedge PHI_2) begin
    if (RES) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      if (tick) count <= '0;
      else      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/bus_timer.sv
// Memory-mapped 16-bit interval timer: bus decode, register file, down-counter and
// active-low interrupt.
module bus_timer
  import bus_periph_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = 16'hD000,
  parameter int          PRESCALE  = 8,
  parameter int          PS_W      = 8
) (
  input  logic        PHI_2,
  input  logic        RES,
  input  logic [15:0] AB,
  input  logic        RW,
  input  logic [7:0]  DB_W,
  output logic [7:0]  DB_R,
  output logic        SEL,
  output logic        IRQ
);

  timer_state_t state;
  logic [15:0]  latch;
  logic [15:0]  counter;
  logic [7:0]   hi_snap;
  logic         cont;
  logic         ie;
  logic         exp_flag;

  logic [1:0] ofs;
  logic       en;
  logic       wr_lo, wr_hi, wr_ctrl, wr_status, rd_lo;
  logic       ps_clr, tick, expire;

  // Full compare of the upper address bits, so nothing outside the 4-byte window aliases in
  assign SEL = (AB[15:2] == BASE_ADDR[15:2]);
  assign ofs = AB[1:0];
  assign en  = (state == ST_RUN);

  assign wr_lo     = SEL && !RW && (ofs == OFS_CNT_LO);
  assign wr_hi     = SEL && !RW && (ofs == OFS_CNT_HI);
  assign wr_ctrl   = SEL && !RW && (ofs == OFS_CTRL);
  assign wr_status = SEL && !RW && (ofs == OFS_STATUS);
  assign rd_lo     = SEL &&  RW && (ofs == OFS_CNT_LO);

  assign ps_clr = wr_hi || (wr_ctrl && DB_W[CTRL_EN] && !en);
  assign expire = tick && (counter == 16'd0);

  timer_prescaler #(
    .PRESCALE (PRESCALE),
    .PS_W     (PS_W)
  ) u_prescaler (
    .PHI_2 (PHI_2),
    .RES   (RES),
    .en    (en),
    .clr   (ps_clr),
    .tick  (tick)
  );

  always_comb begin
    DB_R = 8'h00;
    if (SEL) begin
      case (ofs)
        OFS_CNT_LO: DB_R = counter[7:0];
        OFS_CNT_HI: DB_R = hi_snap;
        OFS_CTRL:   DB_R = {5'b0, ie, cont, en};
        default:    DB_R = {7'b0, exp_flag};
      endcase
    end
  end

  // Register file, counter and IDLE/RUN state; a CNT_HI load beats a same-edge tick, a set of
  // EXP beats a same-edge clear, and an explicit CTRL write beats the one-shot auto-disable.
  always_ff @(posedge PHI_2) begin
    if (RES) begin
      state    <= ST_IDLE;
      latch    <= LATCH_RESET;
      counter  <= LATCH_RESET;
      hi_snap  <= 8'h00;
      cont     <= 1'b0;
      ie       <= 1'b0;
      exp_flag <= 1'b0;
    end else begin
      if (wr_lo) latch[7:0]  <= DB_W;
      if (wr_hi) latch[15:8] <= DB_W;

      // Snapshot uses the pre-edge count so LO/HI reads form one coherent 16-bit value
      if (rd_lo) hi_snap <= counter[15:8];

      if (wr_hi) begin
        counter <= {DB_W, latch[7:0]};
      end else if (tick) begin
        if (counter == 16'd0) begin
          if (cont) counter <= latch;
        end else begin
          counter <= counter - 16'd1;
        end
      end

      if (expire)                               exp_flag <= 1'b1;
      else if (wr_status && DB_W[STATUS_EXP])   exp_flag <= 1'b0;

      if (wr_ctrl) begin
        state <= DB_W[CTRL_EN] ? ST_RUN : ST_IDLE;
        cont  <= DB_W[CTRL_CONT];
        ie    <= DB_W[CTRL_IE];
      end else begin
        case (state)
          ST_RUN:  if (expire && !cont) state <= ST_IDLE;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  // Built only from flops, so the request line cannot glitch on bus activity
  assign IRQ = ~(exp_flag & ie);

endmodule

// File: tb/tb_bus_timer.sv
// Bench for bus_timer: a reset/decode vector table plus hand sequences for one-shot,
// continuous, snapshot and same-edge collisions, all checked through an expectation queue.
module tb_bus_timer;

  logic        PHI_2 = 1'b0;
  logic        RES;
  logic [15:0] AB;
  logic        RW;
  logic [7:0]  DB_W;
  logic [7:0]  DB_R;
  logic        SEL;
  logic        IRQ;

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct {
    string       name;
    logic [15:0] addr;
    logic        rw;
    logic [7:0]  wdata;
    logic        chk_db;
    logic [7:0]  exp_db;
    logic        exp_sel;
    logic        exp_irq;
  } vec_t;

  vec_t exp_q[$];
  vec_t table_v[$];

  bus_timer #(
    .BASE_ADDR (16'hD000),
    .PRESCALE  (8),
    .PS_W      (8)
  ) dut (
    .PHI_2 (PHI_2),
    .RES   (RES),
    .AB    (AB),
    .RW    (RW),
    .DB_W  (DB_W),
    .DB_R  (DB_R),
    .SEL   (SEL),
    .IRQ   (IRQ)
  );

  always #5 PHI_2 = ~PHI_2;

  function automatic vec_t mk(input string name, input logic [15:0] addr, input logic rw,
                              input logic [7:0] wdata, input logic chk_db, input logic [7:0] exp_db,
                              input logic exp_sel, input logic exp_irq);
    vec_t v;
    v.name    = name;
    v.addr    = addr;
    v.rw      = rw;
    v.wdata   = wdata;
    v.chk_db  = chk_db;
    v.exp_db  = exp_db;
    v.exp_sel = exp_sel;
    v.exp_irq = exp_irq;
    return v;
  endfunction

  function automatic vec_t rd(input string name, input logic [15:0] addr,
                              input logic [7:0] exp_db, input logic exp_irq);
    return mk(name, addr, 1'b1, 8'h00, 1'b1, exp_db, 1'b1, exp_irq);
  endfunction

  function automatic vec_t wr(input string name, input logic [15:0] addr,
                              input logic [7:0] data, input logic exp_irq);
    return mk(name, addr, 1'b0, data, 1'b0, 8'h00, 1'b1, exp_irq);
  endfunction

  task automatic check_val(input string name, input logic [7:0] actual, input logic [7:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %02h, expected %02h", name, actual, expected);
    end
  endtask

  task automatic check_output();
    vec_t v;
    if (exp_q.size() == 0) begin
      check_val("scoreboard_empty", 8'h01, 8'h00);
    end else begin
      v = exp_q.pop_front();
      check_val({v.name, "_sel"}, {7'b0, SEL}, {7'b0, v.exp_sel});
      check_val({v.name, "_irq"}, {7'b0, IRQ}, {7'b0, v.exp_irq});
      if (v.chk_db) check_val({v.name, "_db"}, DB_R, v.exp_db);
    end
  endtask

  // One bus cycle: drive after the falling edge, sample mid-cycle, commit on the rising edge
  task automatic apply_stimulus(input vec_t v);
    @(negedge PHI_2);
    AB   = v.addr;
    RW   = v.rw;
    DB_W = v.wdata;
    exp_q.push_back(v);
    #1;
    check_output();
    @(posedge PHI_2);
  endtask

  task automatic idle(input int n);
    @(negedge PHI_2);
    AB   = 16'h0000;
    RW   = 1'b1;
    DB_W = 8'h00;
    repeat (n) @(posedge PHI_2);
  endtask

  initial begin
    RES  = 1'b1;
    AB   = 16'h0000;
    RW   = 1'b1;
    DB_W = 8'h00;

    table_v.push_back(rd("rst_hi_snap",  16'hD001, 8'h00, 1'b1));
    table_v.push_back(rd("rst_ctrl",     16'hD002, 8'h00, 1'b1));
    table_v.push_back(rd("rst_status",   16'hD003, 8'h00, 1'b1));
    table_v.push_back(rd("rst_cnt_lo",   16'hD000, 8'hFF, 1'b1));
    table_v.push_back(rd("rst_cnt_hi",   16'hD001, 8'hFF, 1'b1));
    table_v.push_back(mk("dec_wr_below", 16'hCFFE, 1'b0, 8'h07, 1'b1, 8'h00, 1'b0, 1'b1));
    table_v.push_back(mk("dec_rd_below", 16'hCFFF, 1'b1, 8'h00, 1'b1, 8'h00, 1'b0, 1'b1));
    table_v.push_back(mk("dec_wr_above", 16'hD006, 1'b0, 8'h07, 1'b1, 8'h00, 1'b0, 1'b1));
    table_v.push_back(mk("dec_wr_lo_al", 16'hD004, 1'b0, 8'h55, 1'b1, 8'h00, 1'b0, 1'b1));
    table_v.push_back(mk("dec_wr_hi_al", 16'hD005, 1'b0, 8'h55, 1'b1, 8'h00, 1'b0, 1'b1));
    table_v.push_back(mk("dec_rd_above", 16'hD004, 1'b1, 8'h00, 1'b1, 8'h00, 1'b0, 1'b1));
    table_v.push_back(rd("dec_ctrl",     16'hD002, 8'h00, 1'b1));
    table_v.push_back(rd("dec_cnt_lo",   16'hD000, 8'hFF, 1'b1));
    table_v.push_back(rd("dec_cnt_hi",   16'hD001, 8'hFF, 1'b1));

    repeat (2) @(posedge PHI_2);
    @(negedge PHI_2);
    RES = 1'b0;
    check_val("rst_irq", {7'b0, IRQ}, 8'h01);

    for (int i = 0; i < table_v.size(); i++) apply_stimulus(table_v[i]);

    // One-shot: load 3, expiry lands 32 edges after the enabling write
    apply_stimulus(wr("os_lo",   16'hD000, 8'h03, 1'b1));
    apply_stimulus(wr("os_hi",   16'hD001, 8'h00, 1'b1));
    apply_stimulus(wr("os_ctrl", 16'hD002, 8'h05, 1'b1));
    idle(31);
    apply_stimulus(rd("os_pre_status",  16'hD003, 8'h00, 1'b1));
    apply_stimulus(rd("os_post_status", 16'hD003, 8'h01, 1'b0));
    apply_stimulus(rd("os_ctrl_en0",    16'hD002, 8'h04, 1'b0));
    apply_stimulus(rd("os_cnt_lo",      16'hD000, 8'h00, 1'b0));
    apply_stimulus(wr("os_clear",       16'hD003, 8'h01, 1'b0));
    apply_stimulus(rd("os_cleared",     16'hD003, 8'h00, 1'b1));

    // Continuous: latch 0001 expires every 16 edges and reloads
    apply_stimulus(wr("ct_lo",   16'hD000, 8'h01, 1'b1));
    apply_stimulus(wr("ct_hi",   16'hD001, 8'h00, 1'b1));
    apply_stimulus(wr("ct_ctrl", 16'hD002, 8'h07, 1'b1));
    for (int k = 0; k < 3; k++) begin
      idle((k == 0) ? 15 : 11);
      apply_stimulus(rd($sformatf("ct%0d_pre", k),    16'hD003, 8'h00, 1'b1));
      apply_stimulus(rd($sformatf("ct%0d_exp", k),    16'hD003, 8'h01, 1'b0));
      apply_stimulus(rd($sformatf("ct%0d_reload", k), 16'hD000, 8'h01, 1'b0));
      apply_stimulus(wr($sformatf("ct%0d_clr", k),    16'hD003, 8'h01, 1'b0));
      apply_stimulus(rd($sformatf("ct%0d_post", k),   16'hD003, 8'h00, 1'b1));
    end
    apply_stimulus(wr("ct_stop", 16'hD002, 8'h00, 1'b1));

    // Snapshot: CNT_LO read on the tick edge must capture the pre-decrement high byte
    apply_stimulus(wr("sn_lo",   16'hD000, 8'hFF, 1'b1));
    apply_stimulus(wr("sn_hi",   16'hD001, 8'h12, 1'b1));
    apply_stimulus(wr("sn_ctrl", 16'hD002, 8'h01, 1'b1));
    idle(7);
    apply_stimulus(rd("sn_lo_at_tick", 16'hD000, 8'hFF, 1'b1));
    idle(2);
    apply_stimulus(rd("sn_hi_snap",    16'hD001, 8'h12, 1'b1));
    apply_stimulus(rd("sn_lo_after",   16'hD000, 8'hFE, 1'b1));
    apply_stimulus(wr("sn_stop",       16'hD002, 8'h00, 1'b1));

    // Collision: STATUS clear on the expiry edge loses to the set
    apply_stimulus(wr("co_lo",   16'hD000, 8'h00, 1'b1));
    apply_stimulus(wr("co_hi",   16'hD001, 8'h00, 1'b1));
    apply_stimulus(wr("co_ctrl", 16'hD002, 8'h05, 1'b1));
    idle(7);
    apply_stimulus(wr("co_clr_at_exp", 16'hD003, 8'h01, 1'b1));
    apply_stimulus(rd("co_status",     16'hD003, 8'h01, 1'b0));
    apply_stimulus(rd("co_ctrl_rd",    16'hD002, 8'h04, 1'b0));
    apply_stimulus(wr("co_clr",        16'hD003, 8'h01, 1'b0));
    apply_stimulus(rd("co_cleared",    16'hD003, 8'h00, 1'b1));

    // Collision: CTRL write on a one-shot expiry edge keeps the written EN
    apply_stimulus(wr("ce_ctrl", 16'hD002, 8'h01, 1'b1));
    idle(7);
    apply_stimulus(wr("ce_ctrl_at_exp", 16'hD002, 8'h01, 1'b1));
    apply_stimulus(rd("ce_status",      16'hD003, 8'h01, 1'b1));
    apply_stimulus(rd("ce_ctrl_rd",     16'hD002, 8'h01, 1'b1));
    apply_stimulus(wr("ce_stop",        16'hD002, 8'h00, 1'b1));
    apply_stimulus(wr("ce_clr",         16'hD003, 8'h01, 1'b1));
    apply_stimulus(rd("ce_cleared",     16'hD003, 8'h00, 1'b1));

    // Reset mid-count aborts the pending expiry
    apply_stimulus(wr("mr_ctrl", 16'hD002, 8'h05, 1'b1));
    idle(3);
    @(negedge PHI_2);
    RES = 1'b1;
    @(posedge PHI_2);
    @(negedge PHI_2);
    RES = 1'b0;
    check_val("mr_irq_now", {7'b0, IRQ}, 8'h01);
    idle(12);
    #1;
    check_val("mr_irq_later", {7'b0, IRQ}, 8'h01);
    apply_stimulus(rd("mr_ctrl_rd", 16'hD002, 8'h00, 1'b1));
    apply_stimulus(rd("mr_status",  16'hD003, 8'h00, 1'b1));
    apply_stimulus(rd("mr_cnt_lo",  16'hD000, 8'hFF, 1'b1));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
